token_dispatcher: RTL and testbench
===================================

// Module: token_dispatcher
// PURPOSE
//  Reads a contiguous run of 1024-bit tokens from the token buffer over its dispatcher read port and streams them to
//  the expert array over a valid/ready interface. Read requests are credit-limited against a local FIFO, so the token
//  buffer's fixed read latency never overflows the FIFO and downstream backpressure is absorbed without data loss.
// PARAMETERS
//  DATA_W      1024  token width (bits)
//  ADDR_W      8     token buffer address width; addresses wrap modulo 2**ADDR_W
//  LEN_W       9     command length width (0..256 tokens)
//  FIFO_DEPTH  4     output FIFO entries; also max in-flight reads + queued tokens (power of 2, >=2)
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous reset, active-high
//  cmd_valid       in   1       command offered
//  cmd_ready       out  1       high only in IDLE
//  cmd_base        in   ADDR_W  first token address
//  cmd_len         in   LEN_W   token count
//  buf_grant       in   1       token buffer source select currently = dispatcher
//  buf_req         out  1       read request (one token per cycle)
//  buf_addr        out  ADDR_W  read address
//  buf_rdata       in   DATA_W  read data
//  buf_rdata_valid in   1       read data valid (buffer latency fixed, <= FIFO_DEPTH cycles)
//  tok_valid       out  1       token available
//  tok_ready       in   1       downstream accepts
//  tok_data        out  DATA_W  token payload (FIFO head)
//  tok_idx         out  LEN_W   token index within command, 0-based
//  tok_last        out  1       head is final token of command
//  done            out  1       one-cycle pulse after final token handshake (or zero-length cmd)
//  busy            out  1       state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; cmd_ready = 1 from first cycle after reset; FIFO empty; credits = FIFO_DEPTH; state IDLE.
//  States: IDLE -> ISSUE on cmd_valid&cmd_ready (latch base, len; issue_cnt=0, out_cnt=0).
//   cmd_len==0: IDLE -> DONE directly; no buf_req issued.
//   ISSUE: buf_req=1 iff buf_grant & credits>0 & issue_cnt<len; buf_addr=(base+issue_cnt) mod 2**ADDR_W.
//     Each request: issue_cnt++, credits--. issue_cnt==len -> DRAIN.
//   DRAIN: no requests; wait until out_cnt==len -> DONE.
//   DONE: done=1 for exactly one cycle -> IDLE.
//  buf_req/buf_addr are combinational from registered state and grant; no request when buf_grant=0 (stall, not abort).
//  Credits: decremented per request, incremented per tok_valid&tok_ready; same-cycle request and pop leave count
//   unchanged. credits + in_flight + FIFO occupancy == FIFO_DEPTH at all times.
//  Return: buf_rdata_valid pushes buf_rdata into FIFO with idx=tracked return count; tok_last set when idx==len-1.
//   Pushing into a full FIFO cannot occur by construction; buf_rdata_valid with nothing in flight is ignored.
//  Output: tok_valid = FIFO non-empty; tok_data/idx/last stable while tok_valid & !tok_ready.
//   Push and pop in same cycle on a full FIFO allowed. First-word latency from accepted cmd: 1 + buffer latency.
//  done coincides with state DONE, asserted the cycle after the last handshake; busy=0 in that same cycle? No: busy=1 in DONE.
//  cmd_valid while busy: held off (cmd_ready=0); new command accepted the cycle after DONE.
//  Reset mid-command: state, counters, FIFO cleared in one cycle; late buf_rdata_valid after reset ignored.
// CONFIGURATION
//  TOKEN_DISPATCHER_PERF_EN defined: adds outputs perf_grant_stall[31:0] (cycles in ISSUE with credits>0 &
//   issue_cnt<len & !buf_grant) and perf_bp_stall[31:0] (cycles tok_valid & !tok_ready); both cleared by rst and
//   on command accept, saturate at 32'hFFFF_FFFF.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. rst, cmd base=8'h10 len=4, grant=1, tok_ready=1 -> buf_addr 10,11,12,13 consecutive; tokens idx 0..3,
//     tok_last only on idx 3; done pulse 1 cycle after idx 3 handshake.
//  2. base=8'hFE len=4 -> buf_addr FE,FF,00,01 (wrap); data order preserved.
//  3. len=16, tok_ready=0 for 20 cycles -> exactly FIFO_DEPTH(4) buf_req issued, tok_valid held with idx 0 stable;
//     release ready -> remaining 12 issued, all 16 delivered, no loss or duplicate.
//  4. len=8, buf_grant toggled 1-0-1-0... -> requests only in grant cycles, addresses contiguous, 8 tokens out.
//  5. cmd len=0 -> no buf_req, done pulse, cmd_ready back high next cycle; cmd_valid during busy not accepted.
//  6. rst asserted mid len=16 after 5 tokens -> outputs 0 next cycle, stray rdata_valid ignored; new len=2 cmd OK.

Source files
------------

// File: rtl/token_dispatcher.sv
// token_dispatcher: reads a contiguous run of tokens from the token buffer and
// streams them to the expert array over valid/ready. Read requests are limited
// by credits so in-flight reads plus queued tokens never exceed FIFO_DEPTH.
// Optional build macro TOKEN_DISPATCHER_PERF_EN adds stall counters
// perf_grant_stall and perf_bp_stall.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | issuing buffer reads as grant and credits allow
// DRAIN | all reads issued, waiting for the last token to leave
// DONE  | one-cycle completion pulse
module token_dispatcher #(
  parameter int DATA_W     = 1024,
  parameter int ADDR_W     = 8,
  parameter int LEN_W      = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              buf_grant,
  output logic              buf_req,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [DATA_W-1:0] buf_rdata,
  input  logic              buf_rdata_valid,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic [DATA_W-1:0] tok_data,
  output logic [LEN_W-1:0]  tok_idx,
  output logic              tok_last,
  output logic              done,
`ifdef TOKEN_DISPATCHER_PERF_EN
  output logic              busy,
  output logic [31:0]       perf_grant_stall,
  output logic [31:0]       perf_bp_stall
`else
  output logic              busy
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issue_cnt_q;
  logic [LEN_W-1:0]  ret_cnt_q;
  logic [LEN_W-1:0]  out_cnt_q;
  logic [CW-1:0]     credits_q;
  logic [CW-1:0]     in_flight_q;

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [LEN_W-1:0]  mem_idx  [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [PW:0]       wptr_q, rptr_q;

  logic accept, credit_ok, more, push, pop, last_req, last_pop;

  assign accept    = cmd_valid & cmd_ready;
  assign credit_ok = (credits_q != '0);
  assign more      = (issue_cnt_q < len_q);
  // Returns with nothing outstanding (e.g. stragglers after a reset) are dropped.
  assign push      = buf_rdata_valid & (in_flight_q != '0);
  assign tok_valid = (wptr_q != rptr_q);
  assign pop       = tok_valid & tok_ready;
  assign last_req  = buf_req & (issue_cnt_q == len_q - LEN_W'(1));
  assign last_pop  = pop & (out_cnt_q == len_q - LEN_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (cmd_len == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_req) state_d = S_DRAIN;
      S_DRAIN: if (last_pop) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state; request also gated by grant and credits
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    buf_req   = (state_q == S_ISSUE) & buf_grant & credit_ok & more;
    buf_addr  = base_q + issue_cnt_q[ADDR_W-1:0];
  end

  // Command latch, progress counters, credit and in-flight accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      out_cnt_q   <= '0;
      credits_q   <= CW'(FIFO_DEPTH);
      in_flight_q <= '0;
    end else begin
      if (accept) begin
        base_q      <= cmd_base;
        len_q       <= cmd_len;
        issue_cnt_q <= '0;
        ret_cnt_q   <= '0;
        out_cnt_q   <= '0;
      end else begin
        issue_cnt_q <= issue_cnt_q + LEN_W'(buf_req);
        ret_cnt_q   <= ret_cnt_q + LEN_W'(push);
        out_cnt_q   <= out_cnt_q + LEN_W'(pop);
      end
      credits_q   <= credits_q - CW'(buf_req) + CW'(pop);
      in_flight_q <= in_flight_q + CW'(buf_req) - CW'(push);
    end
  end

  // FIFO pointers; credits guarantee a push never lands on a full FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + (PW+1)'(push);
      rptr_q <= rptr_q + (PW+1)'(pop);
    end
  end

  // FIFO storage: payload plus index and last flag tagged at return time
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr_q[PW-1:0]] <= buf_rdata;
      mem_idx[wptr_q[PW-1:0]]  <= ret_cnt_q;
      mem_last[wptr_q[PW-1:0]] <= (ret_cnt_q == len_q - LEN_W'(1));
    end
  end

  assign tok_data = tok_valid ? mem_data[rptr_q[PW-1:0]] : '0;
  assign tok_idx  = tok_valid ? mem_idx[rptr_q[PW-1:0]]  : '0;
  assign tok_last = tok_valid ? mem_last[rptr_q[PW-1:0]] : 1'b0;

`ifdef TOKEN_DISPATCHER_PERF_EN
  logic grant_stall, bp_stall;
  assign grant_stall = (state_q == S_ISSUE) & credit_ok & more & ~buf_grant;
  assign bp_stall    = tok_valid & ~tok_ready;

  // Saturating stall counters, restarted for every accepted command
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_grant_stall <= '0;
      perf_bp_stall    <= '0;
    end else begin
      if (grant_stall && (perf_grant_stall != 32'hFFFF_FFFF))
        perf_grant_stall <= perf_grant_stall + 32'd1;
      if (bp_stall && (perf_bp_stall != 32'hFFFF_FFFF))
        perf_bp_stall <= perf_bp_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_token_dispatcher.sv
// Testbench for token_dispatcher: directed commands against a fixed-latency
// buffer model; expected tokens and addresses are queued at command accept and
// a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_token_dispatcher;
  localparam int DATA_W = 1024, ADDR_W = 8, LEN_W = 9, FIFO_DEPTH = 4, LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              buf_grant = 1'b1;
  logic              buf_req;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_rdata;
  logic              buf_rdata_valid;
  logic              tok_valid;
  logic              tok_ready = 1'b1;
  logic [DATA_W-1:0] tok_data;
  logic [LEN_W-1:0]  tok_idx;
  logic              tok_last;
  logic              done;
  logic              busy;

  token_dispatcher #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .buf_grant(buf_grant),
    .buf_req(buf_req), .buf_addr(buf_addr), .buf_rdata(buf_rdata),
    .buf_rdata_valid(buf_rdata_valid), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_data(tok_data), .tok_idx(tok_idx), .tok_last(tok_last),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] tok_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W/32; i++) w[i*32 +: 32] = {a, 8'(i), a ^ 8'hBE, 8'h5A};
    return w;
  endfunction

  // Token buffer model: fixed read latency, contents derived from address
  logic                req_s = 1'b0;
  logic [ADDR_W-1:0]   addr_s = '0;
  logic [LAT-1:0]      pv = '0;
  logic [ADDR_W-1:0]   pa [LAT] = '{default: '0};
  logic                stray = 1'b0;
  always @(negedge clk) begin
    req_s  = buf_req;
    addr_s = buf_addr;
  end
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], req_s};
    pa[0] <= addr_s;
    for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
  end
  assign buf_rdata_valid = pv[LAT-1] | stray;
  assign buf_rdata       = tok_word(pa[LAT-1]);

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  idx;
    logic              last;
  } tok_t;
  tok_t              tok_q [$];
  logic [ADDR_W-1:0] addr_q [$];

  // Monitor / scoreboard
  logic              exp_done = 1'b0;
  logic              hold_prev = 1'b0;
  logic [LEN_W-1:0]  prev_idx = '0;
  logic [DATA_W-1:0] prev_data = '0;
  int                req_total = 0;
  int                hs_total = 0;
  int                done_cyc = -1;
  always @(negedge clk) begin
    tok_t e;
    if (rst) begin
      exp_done  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (done || exp_done) check("done_pulse", 64'(done), 64'(exp_done));
      if (done) done_cyc = cyc;
      exp_done = (tok_valid && tok_ready && tok_last) || (cmd_valid && cmd_ready && cmd_len == '0);
      if (hold_prev) begin
        check("hold_valid", 64'(tok_valid), 64'd1);
        check("hold_idx", 64'(tok_idx), 64'(prev_idx));
        n_tests++;
        if (tok_data !== prev_data) begin
          n_fail++;
          $display("FAIL hold_data: got ..%016h expected ..%016h", tok_data[63:0], prev_data[63:0]);
        end
      end
      hold_prev = tok_valid && !tok_ready;
      prev_idx  = tok_idx;
      prev_data = tok_data;
      if (buf_req) begin
        req_total++;
        check("req_only_with_grant", 64'(buf_grant), 64'd1);
        if (addr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL buf_addr: unexpected request at %0h expected none", buf_addr);
        end else check("buf_addr", 64'(buf_addr), 64'(addr_q.pop_front()));
      end
      if (tok_valid && tok_ready) begin
        hs_total++;
        if (tok_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tok_extra: got idx %0d expected no token", tok_idx);
        end else begin
          e = tok_q.pop_front();
          check("tok_idx", 64'(tok_idx), 64'(e.idx));
          check("tok_last", 64'(tok_last), 64'(e.last));
          n_tests++;
          if (tok_data !== e.data) begin
            n_fail++;
            $display("FAIL tok_data: got ..%016h expected ..%016h", tok_data[63:0], e.data[63:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n, output int acc_cyc);
    int t = 0;
    tok_t e;
    cmd_valid = 1'b1; cmd_base = b; cmd_len = n;
    @(negedge clk);
    while (!cmd_ready && t < 300) begin
      check("held_off_busy", 64'(busy), 64'd1);
      t++;
      @(negedge clk);
    end
    acc_cyc = cyc;
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_accept_timeout: got cmd_ready 0 expected 1");
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        addr_q.push_back(8'(int'(b) + i));
        e.data = tok_word(8'(int'(b) + i));
        e.idx  = LEN_W'(i);
        e.last = (i == int'(n) - 1);
        tok_q.push_back(e);
      end
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    @(negedge clk);
    while (!done && t < budget) begin t++; @(negedge clk); end
    check("done_seen", 64'(done), 64'd1);
    tick();
    check("tok_q_drained", 64'(tok_q.size()), 64'd0);
    check("addr_q_drained", 64'(addr_q.size()), 64'd0);
  endtask

  initial begin
    int a, a2, r0, h0, t;
    logic tog_run;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tok_valid", 64'(tok_valid), 64'd0);
    check("rst_buf_req", 64'(buf_req), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tok_idx", 64'(tok_idx), 64'd0);
    check("rst_tok_last", 64'(tok_last), 64'd0);
    check("rst_tok_data", tok_data[63:0], 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();

    // 1: basic run
    send_cmd(8'h10, 9'd4, a);
    wait_done(50);

    // 2: address wrap
    send_cmd(8'hFE, 9'd4, a);
    wait_done(50);

    // 3: backpressure, credit limit
    tok_ready = 1'b0;
    r0 = req_total;
    send_cmd(8'h20, 9'd16, a);
    repeat (20) tick();
    check("bp_req_count", 64'(req_total - r0), 64'd4);
    check("bp_tok_valid", 64'(tok_valid), 64'd1);
    check("bp_tok_idx", 64'(tok_idx), 64'd0);
    tok_ready = 1'b1;
    wait_done(100);
    check("bp_total_req", 64'(req_total - r0), 64'd16);

    // 4: grant toggling
    r0 = req_total;
    tog_run = 1'b1;
    fork
      begin
        while (tog_run) begin tick(); buf_grant = ~buf_grant; end
      end
      begin
        send_cmd(8'h60, 9'd8, a);
        wait_done(100);
        tog_run = 1'b0;
      end
    join
    buf_grant = 1'b1;
    check("grant_req_count", 64'(req_total - r0), 64'd8);

    // 5: zero-length command and hold-off while busy
    r0 = req_total;
    send_cmd(8'h20, 9'd0, a);
    @(negedge clk);
    check("len0_busy_in_done", 64'(busy), 64'd1);
    check("len0_cmd_ready_in_done", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("len0_cmd_ready_after", 64'(cmd_ready), 64'd1);
    check("len0_busy_after", 64'(busy), 64'd0);
    check("len0_no_req", 64'(req_total - r0), 64'd0);
    tick();
    send_cmd(8'h30, 9'd2, a);
    send_cmd(8'h50, 9'd1, a2);
    check("accept_after_done", 64'(a2), 64'(done_cyc + 1));
    wait_done(50);

    // 6: reset mid-command
    h0 = hs_total;
    send_cmd(8'h80, 9'd16, a);
    t = 0;
    while (hs_total < h0 + 5 && t < 100) begin tick(); t++; end
    check("mid_hs_reached", 64'(hs_total - h0), 64'd5);
    rst = 1'b1;
    tok_q.delete();
    addr_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tok_valid", 64'(tok_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_buf_req", 64'(buf_req), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("stray_ignored", 64'(tok_valid), 64'd0);
    tick();
    send_cmd(8'h40, 9'd2, a);
    wait_done(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
